// File: rtl/counter_updown_tristate.sv
// Up/down modulo counter: load, wrap/saturate, tc pulse, sticky flag, tri-state bus.
// Optional prescaler on the step enable: define CNT_PRESCALE_EN.
module counter_updown_tristate #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int unsigned      PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  saturate,
    input  logic                  parallel_load,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  clear_flag,
    input  logic                  out_enable,
`ifdef CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_div,
`endif
    output logic [WIDTH-1:0]      q_bus,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf_sticky
);

    logic             tick;
    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             ovf_d;

    if (WIDTH < 2) begin : g_bad_width
        $error("counter_updown_tristate: WIDTH must be >= 2");
    end

`ifdef CNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_q;
    logic [PRESCALE_W-1:0] psc_d;

    // Prescaler only moves on enabled, non-load cycles.
    always_comb begin
        tick  = (psc_q == prescale_div);
        psc_d = psc_q;
        if (parallel_load) begin
            psc_d = '0;
        end else if (enable) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    if (PRESCALE_W < 1) begin : g_bad_psc
        $error("counter_updown_tristate: PRESCALE_W must be >= 1");
    end

    assign tick = 1'b1;
`endif

    assign step = enable & tick & ~parallel_load;

    // Up treats count above limit as a boundary too (limit lowered mid-count).
    assign at_bound = up_down ? (count >= limit) : (count == '0);

    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        priority case (1'b1)
            parallel_load: begin
                count_d = data_in;
            end
            step & at_bound: begin
                tc_d = 1'b1;
                if (!saturate) begin
                    count_d = up_down ? '0 : limit;
                end
            end
            step: begin
                count_d = up_down ? count + 1'b1 : count - 1'b1;
            end
            default: begin
                count_d = count;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_sticky;
        if (step & at_bound) begin
            ovf_d = 1'b1;
        end else if (clear_flag) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= RESET_VAL;
            tc         <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count      <= count_d;
            tc         <= tc_d;
            ovf_sticky <= ovf_d;
        end
    end

    assign q_bus = out_enable ? count : {WIDTH{1'bz}};

endmodule
